// File: rtl/dac8411_write.sv
// rtl/dac8411_write.sv - DAC8411 serial frame writer with 1-deep pending sample buffer
//
// Purpose:
//   Takes each sample strobed by new_data_flag and shifts it to a TI DAC8411 as a
//   24-bit frame {PD_MODE, word, 6'b0}, MSB first. sclk runs at the clk rate and is
//   high during the first half of each clk cycle in which a bit is being sent.
//   sdin and sync_n change on posedge clk; the DAC samples on the mid-cycle sclk
//   fall, so both have half a clk period of setup and hold.
//   A sample that arrives while a frame is in flight waits in a 1-deep pending
//   buffer; a newer one overwrites it (newest wins) and counts as a drop.
//
// Build option:
//   DAC8411_DROP_CNT_EN - when defined, drop_count is a saturating counter of
//   pending overwrites; when undefined drop_count is tied to zero.
//
// Ports:
//   clk            in   system clock (same clock as the ADC reader)
//   aresetn        in   asynchronous active-low reset
//   new_data_flag  in   1-cycle strobe, data_in valid this cycle
//   data_in        in   sample, straight binary, DAC_WIDTH bits
//   sync_n         out  DAC SYNC, low for the 24 bit cycles of a frame
//   sclk           out  DAC SCLK (clk gated by the registered shift enable)
//   sdin           out  DAC serial data, MSB first
//   busy           out  frame in flight or in sync-high hold
//   drop_count     out  pending overwrites (16 bits, saturating)

module dac8411_write #(
    parameter int         DAC_WIDTH        = 16,
    parameter logic [1:0] PD_MODE          = 2'b00,
    parameter int         SYNC_HIGH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 new_data_flag,
    input  logic [DAC_WIDTH-1:0] data_in,
    output logic                 sync_n,
    output logic                 sclk,
    output logic                 sdin,
    output logic                 busy,
    output logic [15:0]          drop_count
);

    localparam int FRAME_W = 24;
    localparam int PAD_W   = FRAME_W - 2 - DAC_WIDTH;
    localparam int HOLD_W  = (SYNC_HIGH_CYCLES > 1) ? $clog2(SYNC_HIGH_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SYNC_HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [FRAME_W-1:0]     r_shift;
    logic [4:0]             r_bit_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_pend_valid;
    logic [DAC_WIDTH-1:0]   r_pend_data;
    logic                   r_sync_n;
    logic                   r_sdin;
    logic                   r_sclk_en;
    logic                   r_busy;

    logic                   w_hold_done;
    logic                   w_from_pend;
    logic                   w_start;
    logic [DAC_WIDTH-1:0]   w_word;
    logic [FRAME_W-1:0]     w_frame;

    assign w_hold_done = (r_state == S_HOLD) && (r_hold_cnt == '0);

    // The pending sample is always older than a same-cycle strobe, so it goes
    // first; the strobe then refills the buffer without being counted as a drop.
    assign w_from_pend = r_pend_valid && ((r_state == S_IDLE) || w_hold_done);
    assign w_start     = w_from_pend || ((r_state == S_IDLE) && new_data_flag);
    assign w_word      = w_from_pend ? r_pend_data : data_in;
    assign w_frame     = {PD_MODE, w_word, {PAD_W{1'b0}}};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_sync_n     <= 1'b1;
            r_sdin       <= 1'b0;
            r_sclk_en    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Pending buffer: refilled by any strobe that does not start a frame.
            if (w_from_pend) begin
                r_pend_valid <= new_data_flag;
                if (new_data_flag) begin
                    r_pend_data <= data_in;
                end
            end else if (new_data_flag && (r_state != S_IDLE)) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= data_in;
            end

            if (w_start) begin
                // First bit is presented together with the sync_n fall so it is
                // sampled on the first sclk fall in the very next cycle.
                r_state   <= S_SHIFT;
                r_shift   <= w_frame;
                r_sdin    <= w_frame[FRAME_W-1];
                r_bit_cnt <= 5'(FRAME_W - 1);
                r_sync_n  <= 1'b0;
                r_sclk_en <= 1'b1;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        if (r_bit_cnt == 5'd0) begin
                            r_sclk_en  <= 1'b0;
                            r_sync_n   <= 1'b1;
                            r_sdin     <= 1'b0;
                            r_hold_cnt <= HOLD_LOAD;
                            r_state    <= S_HOLD;
                        end else begin
                            r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                            r_sdin    <= r_shift[FRAME_W-2];
                            r_bit_cnt <= r_bit_cnt - 5'd1;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef DAC8411_DROP_CNT_EN
    logic        w_overwrite;
    logic [15:0] r_drop_cnt;

    // A strobe lands on a still-valid pending sample that is not leaving this cycle.
    assign w_overwrite = new_data_flag && r_pend_valid && !w_from_pend;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_drop_cnt <= '0;
        end else if (w_overwrite && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = 16'h0;
`endif

    // Behavioural equivalent of the ODDRE1 output stage: the pad follows the
    // registered enable during the high half of clk and is low in the low half.
    assign sclk   = clk & r_sclk_en;
    assign sync_n = r_sync_n;
    assign sdin   = r_sdin;
    assign busy   = r_busy;

endmodule

// File: tb/tb_dac8411_write.sv
// tb/tb_dac8411_write.sv - randomized self-checking bench for dac8411_write
`timescale 1ns/1ps
module tb_dac8411_write;

    localparam int         SH     = 2;
    localparam logic [1:0] PD     = 2'b10;
    localparam int         PERIOD = 24 + SH;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        new_data_flag = 1'b0;
    logic [15:0] data_in = 16'h0;
    wire         sync_n;
    wire         sclk;
    wire         sdin;
    wire         busy;
    wire  [15:0] drop_count;

    always #5 clk = ~clk;

    dac8411_write #(
        .DAC_WIDTH        (16),
        .PD_MODE          (PD),
        .SYNC_HIGH_CYCLES (SH)
    ) u_dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .new_data_flag (new_data_flag),
        .data_in       (data_in),
        .sync_n        (sync_n),
        .sclk          (sclk),
        .sdin          (sdin),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: transaction level. A frame started from a strobe/pending
    // in cycle t occupies the link until cycle t+PERIOD inclusive.
    int          m_end = -1;
    bit          m_pv = 0;
    logic [15:0] m_pd = 16'h0;
    int          m_drops = 0;
    logic [23:0] exp_frames[$];
    int          exp_start[$];

    function automatic int exp_drop();
`ifdef DAC8411_DROP_CNT_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic push_frame(input logic [15:0] w, input int t);
        exp_frames.push_back({PD, w, 6'b0});
        exp_start.push_back(t + 1);
        m_end = t + PERIOD;
    endtask

    task automatic model_cycle(input logic f, input logic [15:0] d, input int c);
        bit idle;
        bit started;
        idle    = (c > m_end);
        started = 0;
        if (m_pv && (idle || c == m_end)) begin
            push_frame(m_pd, c);
            m_pv    = 0;
            started = 1;
        end
        if (f) begin
            if (idle && !started) begin
                push_frame(d, c);
            end else begin
                if (m_pv) m_drops++;
                m_pv = 1;
                m_pd = d;
            end
        end
    endtask

    task automatic step(input logic f, input logic [15:0] d);
        new_data_flag = f;
        data_in       = d;
        check("busy", busy, (cyc <= m_end));
        model_cycle(f, d, cyc);
        @(posedge clk);
        #1;
        cyc++;
        new_data_flag = 1'b0;
        data_in       = 16'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
    endtask

    // Link monitor: sampled while clk is high; a high sclk here means a falling
    // edge later in this cycle, at which the DAC takes sdin.
    logic        mon_prev_sync = 1'b1;
    logic [23:0] mon_word = '0;
    int          mon_bits = 0;
    int          mon_start = 0;

    always @(posedge clk) begin
        #2;
        if (!aresetn) begin
            mon_prev_sync = 1'b1;
        end else begin
            if (!sync_n) begin
                if (mon_prev_sync) begin
                    mon_word  = '0;
                    mon_bits  = 0;
                    mon_start = cyc;
                end
                if (sclk) begin
                    mon_word = {mon_word[22:0], sdin};
                    mon_bits++;
                end
            end else begin
                if (sclk) check("sclk_outside_frame", 1, 0);
                if (!mon_prev_sync) begin
                    if (exp_frames.size() == 0) begin
                        check("unexpected_frame", mon_word, 24'hFFFFFF);
                    end else begin
                        check("frame_data", mon_word, exp_frames.pop_front());
                        check("frame_bits", mon_bits, 24);
                        check("frame_start", mon_start, exp_start.pop_front());
                    end
                end
            end
            mon_prev_sync = sync_n;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_n", sync_n, 1'b1);
        check("rst_sdin", sdin, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, 16'h0);
        aresetn = 1'b1;
        idle_cycles(2);

        // single frame
        step(1'b1, 16'hA5C3);
        idle_cycles(40);

        // two strobes 5 cycles apart chain without an idle gap
        step(1'b1, 16'h1111);
        idle_cycles(4);
        step(1'b1, 16'h2222);
        idle_cycles(60);

        // three strobes within one frame: middle one is overwritten
        step(1'b1, 16'h1111);
        idle_cycles(3);
        step(1'b1, 16'h2222);
        idle_cycles(3);
        step(1'b1, 16'h3333);
        idle_cycles(60);
        check("drop_after_overwrite", drop_count, exp_drop());

        // reset in the middle of a frame
        step(1'b1, 16'h5A5A);
        idle_cycles(10);
        @(negedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        check("midrst_sync_n", sync_n, 1'b1);
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_sdin", sdin, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_drop", drop_count, 16'h0);
        m_end   = -1;
        m_pv    = 0;
        m_drops = 0;
        exp_frames.delete();
        exp_start.delete();
        @(posedge clk);
        #1;
        cyc++;
        @(posedge clk);
        #1;
        cyc++;
        aresetn = 1'b1;
        idle_cycles(2);
        step(1'b1, 16'hC0DE);
        idle_cycles(40);

        // sample period equal to the frame period: no drops
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'($urandom));
            idle_cycles(PERIOD - 1);
        end
        idle_cycles(40);
        check("drop_at_full_rate", drop_count, exp_drop());
        check("drops_model_full_rate", m_drops, 0);

        // random strobe density, overwrites expected
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 19) == 0), 16'($urandom));
        end
        idle_cycles(80);
        check("drop_random", drop_count, exp_drop());
        check("frames_outstanding", exp_frames.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
